vga_out: RTL and testbench

VGA_OUT -- requirements
Module: vga_out

---
 rtl/vga_out_pkg.sv | 32 +++
 rtl/vga_timing.sv | 40 ++++
 rtl/vga_out.sv | 77 +++++++
 tb/tb_vga_out.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_out_pkg.sv
// Shared VGA timing constants and types for vga_out (640x480-style raster at 12.5 MHz, 2x1 pixel clock).
package vga_out_pkg;

    typedef logic [8:0] rgb9_t;
    typedef logic [8:0] hcnt_t;
    typedef logic [9:0] vcnt_t;

    localparam hcnt_t H_TOTAL      = 9'd400;
    localparam hcnt_t H_ACTIVE     = 9'd320;
    localparam hcnt_t H_SYNC_START = 9'd328;
    localparam hcnt_t H_SYNC_END   = 9'd375;
    localparam hcnt_t IMG_X0       = 9'd32;
    localparam hcnt_t IMG_W        = 9'd256;

    localparam vcnt_t V_TOTAL      = 10'd525;
    localparam vcnt_t V_ACTIVE     = 10'd480;
    localparam vcnt_t V_SYNC_START = 10'd490;
    localparam vcnt_t V_SYNC_END   = 10'd491;

    localparam rgb9_t BORDER_RGB   = 9'h049;

    // Per-pixel control decoded from the counters; travels down the latency pipeline.
    typedef struct packed {
        logic win;
        logic blank;
        logic hsync_n;
        logic vsync_n;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{win: 1'b0, blank: 1'b1, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus raw (undelayed) window, blanking and sync decode.
module vga_timing
    import vga_out_pkg::*;
(
    input  logic  pix_clk,
    input  logic  rst,
    output hcnt_t o_hcnt,
    output vcnt_t o_vcnt,
    output ctl_t  o_ctl
);

    hcnt_t r_hcnt;
    vcnt_t r_vcnt;
    logic  w_h_last;
    logic  w_v_last;

    assign w_h_last = (r_hcnt == H_TOTAL - 9'd1);
    assign w_v_last = (r_vcnt == V_TOTAL - 10'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 9'd1;
        end
    end

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_ctl.win     = (r_hcnt >= IMG_X0) && (r_hcnt < IMG_X0 + IMG_W) && (r_vcnt < V_ACTIVE);
    assign o_ctl.blank   = (r_hcnt >= H_ACTIVE) || (r_vcnt >= V_ACTIVE);
    assign o_ctl.hsync_n = !((r_hcnt >= H_SYNC_START) && (r_hcnt <= H_SYNC_END));
    assign o_ctl.vsync_n = !((r_vcnt >= V_SYNC_START) && (r_vcnt <= V_SYNC_END));

endmodule

// File: rtl/vga_out.sv
// VGA output stage: frame-buffer pointers, FB_LAT-aligned control pipeline and registered pins.
// Define VGA_OUT_BORDER_EN to paint the side borders with BORDER_RGB instead of black.
module vga_out
    import vga_out_pkg::*;
#(
    parameter int FB_LAT = 1
)
(
    input  logic       pix_clk,
    input  logic       rst,
    input  rgb9_t      rgb_buf,
    output logic [7:0] pix_ptr_x,
    output logic [7:0] pix_ptr_y,
    output rgb9_t      rgb,
    output logic       hsync,
    output logic       vsync
);

`ifdef VGA_OUT_BORDER_EN
    localparam rgb9_t BORDER_OUT = BORDER_RGB;
`else
    localparam rgb9_t BORDER_OUT = '0;
`endif

    hcnt_t w_hcnt;
    vcnt_t w_vcnt;
    ctl_t  w_ctl;
    ctl_t  w_ctl_dly;
    ctl_t  r_pipe [FB_LAT];
    rgb9_t r_rgb;
    logic  r_hsync;
    logic  r_vsync;

    vga_timing u_timing (
        .pix_clk (pix_clk),
        .rst     (rst),
        .o_hcnt  (w_hcnt),
        .o_vcnt  (w_vcnt),
        .o_ctl   (w_ctl)
    );

    // Each source row is shown on two consecutive lines, hence vcnt>>1.
    assign pix_ptr_x = w_ctl.win ? 8'(w_hcnt - IMG_X0) : 8'd0;
    assign pix_ptr_y = w_ctl.win ? 8'(w_vcnt >> 1)     : 8'd0;

    // NOTE: the delay stages are reset too, so a reset mid-line cannot leak a stale sync pulse afterwards.
    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FB_LAT; i++) r_pipe[i] <= CTL_IDLE;
        end else begin
            r_pipe[0] <= w_ctl;
            for (int i = 1; i < FB_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_ctl_dly = r_pipe[FB_LAT-1];

    // Output register is the final stage: pins lag the counters by FB_LAT+1 cycles.
    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_hsync <= w_ctl_dly.hsync_n;
            r_vsync <= w_ctl_dly.vsync_n;
            if (w_ctl_dly.blank)    r_rgb <= '0;
            else if (w_ctl_dly.win) r_rgb <= rgb_buf;
            else                    r_rgb <= BORDER_OUT;
        end
    end

    assign rgb   = r_rgb;
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule

// File: tb/tb_vga_out.sv
// Self-checking bench for vga_out: raster model from the timing rules plus pinned literal expectations.
module tb_vga_out;

    localparam int FB_LAT = 1;
`ifdef VGA_OUT_BORDER_EN
    localparam logic [8:0] BORDER_EXP = 9'h049;
`else
    localparam logic [8:0] BORDER_EXP = 9'h000;
`endif

    logic       pix_clk = 1'b0;
    logic       rst     = 1'b1;
    logic [8:0] rgb_buf = 9'h000;
    logic [7:0] pix_ptr_x;
    logic [7:0] pix_ptr_y;
    logic [8:0] rgb;
    logic       hsync;
    logic       vsync;

    int n_checks = 0;
    int n_errors = 0;

    int   cyc     = 0;     // rising edges since the latest reset release
    bit   running = 1'b0;
    int   phase   = 0;
    bit   mode1   = 1'b0;  // 0: rgb_buf held at 1A5, 1: changes every cycle
    int   stamp   = 0;
    logic [8:0] cur_buf  = 9'h1A5;
    logic [8:0] prev_buf = 9'h1A5;

    int   run_len = 0;
    int   n_runs  = 0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int   hs_fall [4] = '{default: -1};
    int   hs_rise [4] = '{default: -1};
    int   vs_fall [2] = '{default: -1};
    int   vs_rise [2] = '{default: -1};
    int   n_hf = 0, n_hr = 0, n_vf = 0, n_vr = 0;

    vga_out #(.FB_LAT(FB_LAT)) dut (
        .pix_clk   (pix_clk),
        .rst       (rst),
        .rgb_buf   (rgb_buf),
        .pix_ptr_x (pix_ptr_x),
        .pix_ptr_y (pix_ptr_y),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Outputs after edge t reflect raster position n = t-FB_LAT-1; window pixels are the rgb_buf of cycle t-1.
    function automatic void model_out(input int t, input logic [8:0] buf_prev,
                                      output logic [8:0] e_rgb, output logic e_hs, output logic e_vs);
        int n, h, v;
        n     = t - FB_LAT - 1;
        e_rgb = 9'h000;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        if (n >= 0) begin
            h    = n % 400;
            v    = (n / 400) % 525;
            e_hs = !(h >= 328 && h <= 375);
            e_vs = !(v == 490 || v == 491);
            if (h < 320 && v < 480) e_rgb = (h >= 32 && h < 288) ? buf_prev : BORDER_EXP;
        end
    endfunction

    function automatic void model_ptr(input int t, output logic [7:0] px, output logic [7:0] py);
        int h, v;
        h  = t % 400;
        v  = (t / 400) % 525;
        px = 8'd0;
        py = 8'd0;
        if (h >= 32 && h < 288 && v < 480) begin
            px = 8'(h - 32);
            py = 8'(v / 2);
        end
    endfunction

    // Stimulus driver: advances the cycle count and presents a new rgb_buf just after each edge.
    always @(posedge pix_clk) begin
        #1;
        stamp++;
        if (running) cyc++;
        else cyc = 0;
        prev_buf = cur_buf;
        cur_buf  = mode1 ? 9'(stamp * 37 + 5) : 9'h1A5;
        rgb_buf  = cur_buf;
    end

    always @(negedge pix_clk) begin : cmp
        logic [8:0] e_rgb;
        logic       e_hs, e_vs;
        logic [7:0] e_px, e_py;
        if (!rst) begin
            check("rst_rgb",   rgb,       32'h0);
            check("rst_hsync", hsync,     32'h1);
            check("rst_vsync", vsync,     32'h1);
            check("rst_ptr_x", pix_ptr_x, 32'h0);
            check("rst_ptr_y", pix_ptr_y, 32'h0);
            prev_hs = 1'b1;
            prev_vs = 1'b1;
            run_len = 0;
        end else if (running) begin
            model_out(cyc, prev_buf, e_rgb, e_hs, e_vs);
            model_ptr(cyc, e_px, e_py);
            check("rgb",   rgb,       e_rgb);
            check("hsync", hsync,     e_hs);
            check("vsync", vsync,     e_vs);
            check("ptr_x", pix_ptr_x, e_px);
            check("ptr_y", pix_ptr_y, e_py);

            case (cyc)
                32:     begin check("ptr_32_0_x", pix_ptr_x, 0);     check("ptr_32_0_y", pix_ptr_y, 0);     end
                687:    begin check("ptr_287_1_x", pix_ptr_x, 255);  check("ptr_287_1_y", pix_ptr_y, 0);    end
                288:    begin check("ptr_288_0_x", pix_ptr_x, 0);    check("ptr_288_0_y", pix_ptr_y, 0);    end
                191632: begin check("ptr_32_479_x", pix_ptr_x, 0);   check("ptr_32_479_y", pix_ptr_y, 239); end
                192100: begin check("ptr_100_480_x", pix_ptr_x, 0);  check("ptr_100_480_y", pix_ptr_y, 0);  end
                12:     check("border_px", rgb, BORDER_EXP);
                102:    if (!mode1) check("window_px", rgb, 9'h1A5);
                352:    check("hblank_px", rgb, 9'h000);
                default: ;
            endcase

            if (!mode1) begin
                if (rgb == 9'h1A5) run_len++;
                else if (run_len > 0) begin
                    check("rgb_run_len", run_len, 256);
                    n_runs++;
                    run_len = 0;
                end
            end

            if (phase == 1) begin
                if (prev_hs && !hsync && n_hf < 4) begin hs_fall[n_hf] = cyc; n_hf++; end
                if (!prev_hs && hsync && n_hr < 4) begin hs_rise[n_hr] = cyc; n_hr++; end
            end else if (phase == 2) begin
                if (prev_vs && !vsync && n_vf < 2) begin vs_fall[n_vf] = cyc; n_vf++; end
                if (!prev_vs && vsync && n_vr < 2) begin vs_rise[n_vr] = cyc; n_vr++; end
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge pix_clk);
            #3;
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (10) @(posedge pix_clk);
        #3;
        check("rst10_rgb",   rgb,       32'h0);
        check("rst10_hsync", hsync,     32'h1);
        check("rst10_vsync", vsync,     32'h1);
        check("rst10_ptr_x", pix_ptr_x, 32'h0);
        check("rst10_ptr_y", pix_ptr_y, 32'h0);
        rst     = 1'b1;
        running = 1'b1;
        phase   = 1;

        wait_cyc(4000);
        mode1 = 1'b1;

        // Reset lands while the raster sits at hcnt=150, vcnt=300.
        wait_cyc(120150);
        rst     = 1'b0;
        running = 1'b0;
        #1;
        check("midrst_rgb",   rgb,       32'h0);
        check("midrst_hsync", hsync,     32'h1);
        check("midrst_vsync", vsync,     32'h1);
        check("midrst_ptr_x", pix_ptr_x, 32'h0);
        check("midrst_ptr_y", pix_ptr_y, 32'h0);
        repeat (5) @(posedge pix_clk);
        #3;
        rst     = 1'b1;
        running = 1'b1;
        phase   = 2;

        wait_cyc(406902);

        check("hs_first_fall", hs_fall[0], 330);
        for (int i = 0; i < 3; i++) begin
            check("hs_low_width", hs_rise[i] - hs_fall[i], 48);
            check("hs_period",    hs_fall[i+1] - hs_fall[i], 400);
        end
        check("rgb_runs_seen", n_runs, 10);
        check("vs_first_fall", vs_fall[0], 196002);
        check("vs_low_width",  vs_rise[0] - vs_fall[0], 800);
        check("vs_period",     vs_fall[1] - vs_fall[0], 210000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #7000000;
        $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
